key_filter_multi: RTL
=====================

# key_filter_multi

Parametrised multi-channel successor to the single-key debouncer. Debounces KEY_W active-low key inputs independently. Per channel it reports:
- a stable pressed level;
- one-cycle press and release events;
- a one-cycle long-press event;
- optionally, auto-repeat events.

Sits between the board key pins and the user-interface control logic (menu FSMs, counters, LED/segment drivers).

## Interface
- KEY_W, 4, number of independent key channels (1..32)
- DEB_MAX, 20'd999_999, consecutive stable raw cycles required to accept a press or release (20 ms at 50 MHz)
- LONG_MAX, 32'd99_999_999, cycles after the press event at which key_long fires (2 s at 50 MHz)
- REP_MAX, 32'd9_999_999, auto-repeat period in cycles after key_long (200 ms); used only with KEY_REPEAT_EN
- sys_clk  input  1  system clock
- sys_rst  input  1  synchronous, active-high reset
- key_in  input  KEY_W  raw key pins, asynchronous, 0 = pressed
- key_state  output  KEY_W  debounced level, 1 = pressed
- key_press  output  KEY_W  one-cycle pulse on accepted press
- key_release  output  KEY_W  one-cycle pulse on accepted release
- key_long  output  KEY_W  one-cycle pulse when held LONG_MAX cycles
- key_repeat  output  KEY_W  one-cycle repeat pulse; constant 0 without KEY_REPEAT_EN

## Operation
- Each bit passes a 2-flop synchronizer. Both flops reset to 1 (released). The synchronizer output is "raw".
- Per-channel FSM with states IDLE, DEB_DN, HELD, DEB_UP:
  - IDLE, raw=0: go to DEB_DN, deb_cnt<=1.
  - DEB_DN, raw=1: go to IDLE, deb_cnt<=0. This rejects the glitch with no event.
  - DEB_DN, raw=0, deb_cnt==DEB_MAX: go to HELD, key_press<=1, hold_cnt<=0.
  - DEB_DN, raw=0, otherwise: deb_cnt++.
  - HELD, raw=1: go to DEB_UP, deb_cnt<=1.
  - HELD, raw=0: hold_cnt advances (see below).
  - DEB_UP, raw=0: return to HELD, deb_cnt<=0. hold_cnt is not cleared; the bounce counts as still held.
  - DEB_UP, raw=1, deb_cnt==DEB_MAX: go to IDLE, key_release<=1.
  - DEB_UP, raw=1, otherwise: deb_cnt++.
- key_state = 1 in HELD and DEB_UP, 0 in IDLE and DEB_DN. It is registered with the FSM.
- hold_cnt:
  - increments every cycle in HELD and DEB_UP;
  - saturates at LONG_MAX;
  - key_long<=1 on the cycle hold_cnt transitions LONG_MAX-1 → LONG_MAX, so it fires at most once per press.
- Event pulses are registered and last exactly one cycle. key_press and key_release never assert in the same cycle on one channel.
- Channels are fully independent. Simultaneous events on several channels are all reported in the same cycle.
- Counter widths are $clog2(MAX+1) of the respective parameter. No wrap-around: counters stop at their maximum.

## Timing
- Reset (sys_rst=1 at a sys_clk edge):
  - all FSMs go to IDLE and all counters to 0;
  - all outputs go to 0 at that edge.
- Reset mid-debounce or mid-hold discards the state with no event. After reset release a held key must re-debounce to produce key_press.
- Press latency, with edge 0 = first edge sampling key_in low and the input held stable:
  - key_press is high in the cycle after edge DEB_MAX+2;
  - key_state rises at the same edge.
- Release latency is symmetric: DEB_MAX+2 edges from the first high sample to key_release.
- A bounce shorter than DEB_MAX cycles yields no event and key_state does not change.
- key_long follows key_press by exactly LONG_MAX cycles if the key is held.

## Configuration
- KEY_REPEAT_EN defined:
  - after key_long, a rep_cnt (cleared at key_long) runs in HELD and DEB_UP;
  - key_repeat pulses every REP_MAX cycles while the key is held;
  - it stops on entry to IDLE or on reset.
- KEY_REPEAT_EN undefined: rep_cnt is not built and key_repeat is tied to 0.

## Structure
- Shared package key_pkg holds:
  - the FSM state enum (IDLE, DEB_DN, HELD, DEB_UP), 2-bit encoding;
  - the default timing constants for 50 MHz.
- Sub-module key_filter_chan holds one channel: synchronizer, FSM, counters and pulses. The top generates KEY_W instances.

## Test plan
Parameters for all scenarios: DEB_MAX=4, LONG_MAX=20, REP_MAX=8, KEY_W=2.
- Clean press/release: key_in[0] 1→0 held 30 cycles, then 1.
  - key_press[0] is high one cycle, 6 edges after the first low sample;
  - key_release[0] follows the same way 6 edges after the release;
  - key_state[0] is high between them.
- Bounce rejection: key_in[0] low for 3 cycles, high 2, repeated 5 times.
  - no key_press and key_state stays 0;
  - then held low gives key_press 6 edges after the last falling edge.
- Long press: hold key_in[1] low for 40 cycles.
  - key_press[1] once;
  - key_long[1] exactly 20 cycles later, once;
  - key_release[1] after release.
- Release bounce while held: after key_press, key_in high 2 cycles then low again.
  - no key_release;
  - hold_cnt continues, so key_long still fires 20 cycles after key_press.
- Simultaneous channels plus reset: both keys pressed on the same cycle.
  - both key_press bits assert in the same cycle;
  - sys_rst asserted mid-hold clears all outputs next edge with no key_release;
  - keys still held re-produce key_press 6 edges after reset release.
- KEY_REPEAT_EN: hold 50 cycles.
  - key_repeat pulses at key_long+8, +16, +24;
  - without the macro key_repeat stays 0.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and 50 MHz timing defaults for the key filter.
// KEY_REPEAT_EN enables per-channel auto-repeat.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DEB_DN = 2'd1,
    HELD   = 2'd2,
    DEB_UP = 2'd3
  } key_st_t;

  localparam logic [19:0] DEB_MAX_DEF  = 20'd999_999;
  localparam logic [31:0] LONG_MAX_DEF = 32'd99_999_999;
  localparam logic [31:0] REP_MAX_DEF  = 32'd9_999_999;

endpackage

// File: rtl/key_filter_chan.sv
// One debounced key channel: synchronizer, FSM, hold and repeat counters.
// KEY_REPEAT_EN builds the auto-repeat counter.
module key_filter_chan
  import key_pkg::*;
#(
  parameter logic [19:0] DEB_MAX  = DEB_MAX_DEF,
  parameter logic [31:0] LONG_MAX = LONG_MAX_DEF
`ifdef KEY_REPEAT_EN
  ,
  parameter logic [31:0] REP_MAX  = REP_MAX_DEF
`endif
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_repeat
);

  localparam int DW = $clog2(DEB_MAX + 1);
  localparam int LW = $clog2(LONG_MAX + 1);
  localparam logic [DW-1:0] DEB_LIM  = DW'(DEB_MAX);
  localparam logic [LW-1:0] LONG_LIM = LW'(LONG_MAX);
  localparam logic [LW-1:0] LONG_PRE = LW'(LONG_MAX - 32'd1);

  key_st_t       st;
  logic [1:0]    sync;
  logic [DW-1:0] deb_cnt;
  logic [LW-1:0] hold_cnt;
  logic          raw;
  logic          held;

  assign raw  = sync[1];
  assign held = (st == HELD) || (st == DEB_UP);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync        <= 2'b11;
      st          <= IDLE;
      deb_cnt     <= '0;
      hold_cnt    <= '0;
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
    end else begin
      sync        <= {sync[0], key_in};
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      // Bounces inside DEB_UP still count as held time.
      if (held) begin
        if (hold_cnt != LONG_LIM) hold_cnt <= hold_cnt + 1'b1;
        key_long <= (hold_cnt == LONG_PRE);
      end
      unique case (st)
        IDLE: begin
          if (!raw) begin
            st      <= DEB_DN;
            deb_cnt <= DW'(1);
          end
        end
        DEB_DN: begin
          if (raw) begin
            st      <= IDLE;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LIM) begin
            st        <= HELD;
            deb_cnt   <= '0;
            hold_cnt  <= '0;
            key_press <= 1'b1;
            key_state <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        HELD: begin
          if (raw) begin
            st      <= DEB_UP;
            deb_cnt <= DW'(1);
          end
        end
        DEB_UP: begin
          if (!raw) begin
            st      <= HELD;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LIM) begin
            st          <= IDLE;
            deb_cnt     <= '0;
            key_release <= 1'b1;
            key_state   <= 1'b0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REP_MAX + 1);
  localparam logic [RW-1:0] REP_PRE = RW'(REP_MAX - 32'd1);

  logic [RW-1:0] rep_cnt;
  logic          rep_on;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rep_cnt    <= '0;
      rep_on     <= 1'b0;
      key_repeat <= 1'b0;
    end else begin
      key_repeat <= 1'b0;
      if (!held) begin
        rep_on  <= 1'b0;
        rep_cnt <= '0;
      end else if (hold_cnt == LONG_PRE) begin
        rep_on  <= 1'b1;
        rep_cnt <= '0;
      end else if (rep_on) begin
        if (rep_cnt == REP_PRE) begin
          rep_cnt    <= '0;
          key_repeat <= 1'b1;
        end else begin
          rep_cnt <= rep_cnt + 1'b1;
        end
      end
    end
  end
`else
  assign key_repeat = 1'b0;
`endif

endmodule

// File: rtl/key_filter_multi.sv
// KEY_W independent active-low key debouncers with press/release/long events.
// KEY_REPEAT_EN adds auto-repeat pulses after a long press.
module key_filter_multi
  import key_pkg::*;
#(
  parameter int          KEY_W    = 4,
  parameter logic [19:0] DEB_MAX  = DEB_MAX_DEF,
  parameter logic [31:0] LONG_MAX = LONG_MAX_DEF,
  parameter logic [31:0] REP_MAX  = REP_MAX_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_state,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic [KEY_W-1:0] key_long,
  output logic [KEY_W-1:0] key_repeat
);

  for (genvar i = 0; i < KEY_W; i++) begin : g_chan
    key_filter_chan #(
      .DEB_MAX (DEB_MAX),
      .LONG_MAX(LONG_MAX)
`ifdef KEY_REPEAT_EN
      ,
      .REP_MAX (REP_MAX)
`endif
    ) u_chan (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .key_in     (key_in[i]),
      .key_state  (key_state[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i]),
      .key_repeat (key_repeat[i])
    );
  end

endmodule
